// File: rtl/video_seq_pkg.sv
// Shared definitions for the video pattern sequencer: FSM state encodings
// and the frame counter width.
package video_seq_pkg;

  localparam int FCNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AUTO = 2'd1,
    ST_PEND = 2'd2
  } state_e;

endpackage

// File: rtl/frame_tick_gen.sv
// Frame tick generator: registers the active-low vsync and flags its falling
// edge. The tick is combinational from the stored sample and the live input,
// so the sequencer acts on the first edge that samples vsync low.
module frame_tick_gen (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  output logic frame_tick
);

  logic vs_q_r;

  // Previous vsync sample; resets high so a low vsync right after reset reads as an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q_r <= 1'b1;
    end else begin
      vs_q_r <= vsync;
    end
  end

  assign frame_tick = vs_q_r & ~vsync;

endmodule

// File: rtl/video_pattern_sequencer.sv
// Video pattern sequencer: picks the pattern shown by the RGB generator.
// Auto-advances every FRAMES_PER_STEP frames, takes manual requests over a
// valid/ready handshake, and only ever changes the select on a frame tick.
module video_pattern_sequencer
  import video_seq_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 120,
  parameter int NUM_PATTERNS    = 4,
  parameter int SEL_W           = 2
) (
  input  logic              i_pixclk,
  input  logic              i_reset_n,
  input  logic              i_enable,
  input  logic              i_vsync,
  input  logic              i_req_valid,
  input  logic [SEL_W-1:0]  i_req_pattern,
  output logic              o_req_ready,
  output logic [SEL_W-1:0]  o_pattern_sel,
  output logic              o_swap,
  output logic [FCNT_W-1:0] o_frame_cnt,
  output logic [1:0]        o_state
);

  localparam logic [SEL_W-1:0]  LAST_PAT    = SEL_W'(NUM_PATTERNS - 1);
  localparam logic [SEL_W:0]    NUM_PAT_EXT = (SEL_W + 1)'(NUM_PATTERNS);
  localparam logic [FCNT_W-1:0] LAST_CNT    = FCNT_W'(FRAMES_PER_STEP - 1);

  // Out-of-range requests map to the highest valid pattern
  function automatic logic [SEL_W-1:0] clamp_pattern(input logic [SEL_W-1:0] pat);
    if ({1'b0, pat} >= NUM_PAT_EXT) begin
      clamp_pattern = LAST_PAT;
    end else begin
      clamp_pattern = pat;
    end
  endfunction

  state_e             state_r, state_s;
  logic [SEL_W-1:0]   sel_r, sel_s;
  logic [SEL_W-1:0]   req_pat_r, req_pat_s;
  logic [FCNT_W-1:0]  cnt_r, cnt_s;
  logic               swap_r, swap_s;
  logic               frame_tick_s;
  logic               accept_s;

  frame_tick_gen u_tick (
    .clk        (i_pixclk),
    .rst_n      (i_reset_n),
    .vsync      (i_vsync),
    .frame_tick (frame_tick_s)
  );

  assign o_req_ready = (state_r != ST_PEND);
  assign accept_s    = i_req_valid & o_req_ready;

  // Next-state and next-output decode; requests beat both enable and the auto step
  always_comb begin
    state_s   = state_r;
    sel_s     = sel_r;
    req_pat_s = req_pat_r;
    cnt_s     = cnt_r;
    swap_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          req_pat_s = clamp_pattern(i_req_pattern);
          state_s   = ST_PEND;
        end else if (i_enable) begin
          cnt_s   = '0;
          state_s = ST_AUTO;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_AUTO: begin
        if (accept_s) begin
          req_pat_s = clamp_pattern(i_req_pattern);
          state_s   = ST_PEND;
        end else if (!i_enable) begin
          state_s = ST_IDLE;
        end else if (frame_tick_s) begin
          if (cnt_r == LAST_CNT) begin
            cnt_s  = '0;
            sel_s  = (sel_r == LAST_PAT) ? '0 : sel_r + SEL_W'(1);
            swap_s = 1'b1;
          end else begin
            cnt_s = cnt_r + FCNT_W'(1);
          end
        end else begin
          state_s = ST_AUTO;
        end
      end
      ST_PEND: begin
        if (frame_tick_s) begin
          sel_s   = req_pat_r;
          swap_s  = 1'b1;
          cnt_s   = '0;
          state_s = i_enable ? ST_AUTO : ST_IDLE;
        end else begin
          state_s = ST_PEND;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, select, counter, request latch and swap pulse registers
  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r   <= ST_IDLE;
      sel_r     <= '0;
      req_pat_r <= '0;
      cnt_r     <= '0;
      swap_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      sel_r     <= sel_s;
      req_pat_r <= req_pat_s;
      cnt_r     <= cnt_s;
      swap_r    <= swap_s;
    end
  end

  assign o_pattern_sel = sel_r;
  assign o_swap        = swap_r;
  assign o_frame_cnt   = cnt_r;
  assign o_state       = state_r;

endmodule
